// File: rtl/fsm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fsm_ctrl_pkg
// Shared definitions for the programmable micro-sequencer.
//   - op_e            : register action opcodes
//   - sel_width       : width of a select field (single-valued selects use 1 bit)
//   - calc_sw/csw/aw/iw/total : instruction field widths and chain length
//   - cond_always_code: the lowest cond_sel code that means "always true"
// ---------------------------------------------------------------------------
package fsm_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_DEC  = 2'b10,
    OP_INC  = 2'b11
  } op_e;

  // A select over a single item still occupies one (ignored) bit
  function automatic int sel_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  function automatic int calc_sw(input int state_count);
    return sel_width(state_count);
  endfunction

  // Codes cover every input, every register-zero flag and one "always" code
  function automatic int calc_csw(input int in_width, input int reg_count);
    return $clog2(in_width + reg_count + 1);
  endfunction

  function automatic int calc_aw(input int reg_count, input int const_count);
    return 2 + sel_width(reg_count) + sel_width(const_count);
  endfunction

  function automatic int calc_iw(input int state_count, input int in_width,
                                 input int reg_count, input int const_count);
    return calc_sw(state_count) + calc_csw(in_width, reg_count) + 1
           + 2 * calc_aw(reg_count, const_count);
  endfunction

  function automatic int calc_total(input int state_count, input int in_width,
                                    input int reg_count, input int const_count,
                                    input int const_width);
    return state_count * calc_iw(state_count, in_width, reg_count, const_count)
           + const_count * const_width;
  endfunction

  function automatic int cond_always_code(input int in_width, input int reg_count);
    return in_width + reg_count;
  endfunction

endpackage

// File: rtl/fsm_prog_mem.sv
// ---------------------------------------------------------------------------
// fsm_prog_mem
// Serial program/constant store. While prog_enable is high the chain shifts
// right by one bit per clock with prog_data entering at the top, so the first
// bit sent ends up at bit 0. Reads are purely combinational.
// Ports:
//   clock, rst        : clock, async active-high reset (clears the chain)
//   prog_enable       : shift enable
//   prog_data         : serial input bit
//   state             : selects the instruction word to present
//   const_sel         : selects the constant to present
//   instr             : instruction word for `state`
//   const_val         : constant selected by `const_sel` (0 if out of range)
// ---------------------------------------------------------------------------
module fsm_prog_mem
  import fsm_ctrl_pkg::*;
#(
  parameter int STATE_COUNT = 16,
  parameter int IN_WIDTH    = 4,
  parameter int REG_COUNT   = 4,
  parameter int CONST_WIDTH = 16,
  parameter int CONST_COUNT = 4,
  localparam int SW    = calc_sw(STATE_COUNT),
  localparam int IW    = calc_iw(STATE_COUNT, IN_WIDTH, REG_COUNT, CONST_COUNT),
  localparam int CSELW = sel_width(CONST_COUNT)
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   prog_enable,
  input  logic                   prog_data,
  input  logic [SW-1:0]          state,
  input  logic [CSELW-1:0]       const_sel,
  output logic [IW-1:0]          instr,
  output logic [CONST_WIDTH-1:0] const_val
);

  localparam int TOTAL = calc_total(STATE_COUNT, IN_WIDTH, REG_COUNT,
                                    CONST_COUNT, CONST_WIDTH);
  localparam int CONST_BASE = STATE_COUNT * IW;

  logic [TOTAL-1:0]       chain;
  logic [IW-1:0]          instr_mem [STATE_COUNT];
  logic [CONST_WIDTH-1:0] const_mem [CONST_COUNT];

  // Shift register holding the whole program image
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else if (prog_enable) begin
      chain <= {prog_data, chain[TOTAL-1:1]};
    end
  end

  // Fixed slicing of the chain into words so reads are plain array indexing
  for (genvar s = 0; s < STATE_COUNT; s++) begin : g_instr
    assign instr_mem[s] = chain[s*IW +: IW];
  end

  for (genvar c = 0; c < CONST_COUNT; c++) begin : g_const
    assign const_mem[c] = chain[CONST_BASE + c*CONST_WIDTH +: CONST_WIDTH];
  end

  // Combinational read; a select beyond the populated constants reads zero
  always_comb begin
    instr     = instr_mem[state];
    const_val = '0;
    for (int c = 0; c < CONST_COUNT; c++) begin
      if (int'(const_sel) == c) const_val = const_mem[c];
    end
  end

endmodule

// File: rtl/fsm_controller_multi.sv
// ---------------------------------------------------------------------------
// fsm_controller_multi
// Programmable micro-sequencer. Each enabled cycle evaluates the current
// state's condition, applies either the then- or else-action to one counter
// register and moves to jump_target (condition true) or state+1.
// Ports:
//   clock, rst   : clock, async active-high reset
//   prog_enable  : shift program bits in; holds sequencer and registers at 0
//   prog_data    : serial program bit
//   run          : execute one instruction this cycle
//   in           : condition inputs (already synchronised)
//   state        : current program state
//   reg_zero     : per-register zero flags
// ---------------------------------------------------------------------------
module fsm_controller_multi
  import fsm_ctrl_pkg::*;
#(
  parameter int STATE_COUNT = 16,
  parameter int IN_WIDTH    = 4,
  parameter int REG_COUNT   = 4,
  parameter int CONST_WIDTH = 16,
  parameter int CONST_COUNT = 4,
  localparam int SW = calc_sw(STATE_COUNT)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 prog_enable,
  input  logic                 prog_data,
  input  logic                 run,
  input  logic [IN_WIDTH-1:0]  in,
  output logic [SW-1:0]        state,
  output logic [REG_COUNT-1:0] reg_zero
);

  localparam int CSW   = calc_csw(IN_WIDTH, REG_COUNT);
  localparam int AW    = calc_aw(REG_COUNT, CONST_COUNT);
  localparam int IW    = calc_iw(STATE_COUNT, IN_WIDTH, REG_COUNT, CONST_COUNT);
  localparam int RSW   = sel_width(REG_COUNT);
  localparam int CSELW = sel_width(CONST_COUNT);

  localparam int JUMP_LSB = 0;
  localparam int CSEL_LSB = SW;
  localparam int INV_BIT  = SW + CSW;
  localparam int THEN_LSB = SW + CSW + 1;
  localparam int ELSE_LSB = THEN_LSB + AW;

  logic [IW-1:0]          instr;
  logic [CONST_WIDTH-1:0] const_val;
  logic [CONST_WIDTH-1:0] regs     [REG_COUNT];
  logic [CONST_WIDTH-1:0] reg_next [REG_COUNT];

  logic [SW-1:0]    jump_target;
  logic [CSW-1:0]   cond_sel;
  logic             cond_inv;
  logic             cond_raw;
  logic             cond_result;
  logic [AW-1:0]    action;
  op_e              op;
  logic [RSW-1:0]   reg_sel;
  logic [CSELW-1:0] const_sel;
  logic [SW-1:0]    state_next;
  int               reg_idx;

  fsm_prog_mem #(
    .STATE_COUNT (STATE_COUNT),
    .IN_WIDTH    (IN_WIDTH),
    .REG_COUNT   (REG_COUNT),
    .CONST_WIDTH (CONST_WIDTH),
    .CONST_COUNT (CONST_COUNT)
  ) u_prog_mem (
    .clock       (clock),
    .rst         (rst),
    .prog_enable (prog_enable),
    .prog_data   (prog_data),
    .state       (state),
    .const_sel   (const_sel),
    .instr       (instr),
    .const_val   (const_val)
  );

  for (genvar k = 0; k < REG_COUNT; k++) begin : g_zero
    assign reg_zero[k] = (regs[k] == '0);
  end

  // Instruction decode and condition evaluation. Codes past the register
  // flags all mean "always true", so raw defaults to 1.
  always_comb begin
    jump_target = instr[JUMP_LSB +: SW];
    cond_sel    = instr[CSEL_LSB +: CSW];
    cond_inv    = instr[INV_BIT];
    cond_raw    = 1'b1;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (int'(cond_sel) == i) cond_raw = in[i];
    end
    for (int k = 0; k < REG_COUNT; k++) begin
      if (int'(cond_sel) == IN_WIDTH + k) cond_raw = reg_zero[k];
    end
    cond_result = cond_raw ^ cond_inv;
    action      = cond_result ? instr[THEN_LSB +: AW] : instr[ELSE_LSB +: AW];
    op          = op_e'(action[1:0]);
    reg_sel     = action[2 +: RSW];
    const_sel   = action[2 + RSW +: CSELW];
    state_next  = cond_result ? jump_target : state + SW'(1);
  end

  // Register action: only the selected register changes; a select past the
  // last register matches nothing and behaves as NOP. Dec/inc wrap naturally.
  always_comb begin
    reg_idx = (REG_COUNT == 1) ? 0 : int'(reg_sel);
    for (int k = 0; k < REG_COUNT; k++) begin
      reg_next[k] = regs[k];
      if (k == reg_idx) begin
        case (op)
          OP_LOAD: reg_next[k] = const_val;
          OP_DEC:  reg_next[k] = regs[k] - CONST_WIDTH'(1);
          OP_INC:  reg_next[k] = regs[k] + CONST_WIDTH'(1);
          default: reg_next[k] = regs[k];
        endcase
      end
    end
  end

  // State and register file; programming mode overrides run and holds the
  // sequencer at its start point
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= '0;
      for (int k = 0; k < REG_COUNT; k++) regs[k] <= '0;
    end else if (prog_enable) begin
      state <= '0;
      for (int k = 0; k < REG_COUNT; k++) regs[k] <= '0;
    end else if (run) begin
      state <= state_next;
      for (int k = 0; k < REG_COUNT; k++) regs[k] <= reg_next[k];
    end
  end

endmodule
